// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
  } arb_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // Behavioural round-robin pick over up to 8 requesters, starting after 'last'.
  function automatic rr_pick_t rr_pick(input logic [7:0] req, input logic [2:0] last,
                                       input int unsigned num_req);
    rr_pick_t    r;
    int unsigned k;
    r = '0;
    for (int unsigned i = 1; i <= num_req; i++) begin
      k = (32'(last) + i) % num_req;
      if (!r.found && req[k]) begin
        r.found = 1'b1;
        r.idx   = 3'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side handshake and FIFO write-port bundle; master is the arbiter side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  logic                          fifo_full;

  modport master (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: rotate so last+1 is bit 0, take lowest set bit, un-rotate.
module rr_priority_picker
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] rot;
  int unsigned        start;
  int unsigned        k;
  int unsigned        pos;

  always_comb begin
    start = 32'(last) + 1;
    if (start >= NUM_REQ) start = start - NUM_REQ;

    rot = '0;
    k   = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = i + start;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      rot[i] = req[k];
    end

    found = |rot;
    pos   = 0;
    for (int unsigned i = NUM_REQ; i > 0; i--) begin
      if (rot[i-1]) pos = i - 1;
    end

    pos = pos + start;
    if (pos >= NUM_REQ) pos = pos - NUM_REQ;
    idx = IDX_W'(pos);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ producers in bounded bursts.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned MAX_BURST  = 4,
  localparam int unsigned IDX_W      = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.master  bus,
  output logic [IDX_W-1:0]   grant_id,
  output logic               busy
);

  arb_state_t       state, state_nxt;
  logic [3:0]       beat_cnt;
  logic [IDX_W-1:0] last_grant;
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic             xfer;
  logic             rel;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req   (bus.req_valid),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant_id   <= '0;
      beat_cnt   <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (rel) begin
            last_grant <= grant_id;
            beat_cnt   <= '0;
          end else if (xfer) begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Release on a dropped valid never coincides with a transfer, so full only freezes the burst.
  always_comb begin
    xfer      = 1'b0;
    rel       = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_found) state_nxt = GRANT;
      end
      GRANT: begin
        xfer = bus.req_valid[grant_id] & ~bus.fifo_full;
        rel  = ~bus.req_valid[grant_id] | (xfer & (beat_cnt == 4'(MAX_BURST - 1)));
        if (rel) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready           = '0;
    bus.req_ready[grant_id] = xfer;
    bus.fifo_wr_en          = xfer;
    bus.fifo_wr_data        = '0;
    busy                    = (state == GRANT);
    if (state == GRANT)
      bus.fifo_wr_data = bus.req_data[32'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, streaming, round-robin, back-pressure, release, FIFO integration.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] grant_id;
  logic       busy;

  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus_if ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if.master),
    .grant_id (grant_id),
    .busy     (busy)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc_n = 0;
  logic        bp    = 1'b0;
  logic        integ = 1'b0;
  logic [3:0]  en    = 4'hF;
  logic [15:0] src_q [4][$];
  logic [15:0] mq [$];
  int          rd [$];
  int          wr_data [$];
  int          wr_gnt [$];
  int          wr_cyc [$];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NR; i++) src_q[i].delete();
    mq.delete();
    rd.delete();
    wr_data.delete();
    wr_gnt.delete();
    wr_cyc.delete();
  endtask

  // Drive one cycle's inputs from the source queues, settle, then log the cycle.
  task automatic drive_sample();
    logic [3:0]  v;
    logic [63:0] d;
    v = '0;
    d = '0;
    for (int i = 0; i < NR; i++) begin
      if (en[i] && src_q[i].size() > 0) begin
        v[i]          = 1'b1;
        d[i*DW +: DW] = src_q[i][0];
      end
    end
    bus_if.fifo_full = integ ? (mq.size() >= 16) : bp;
    bus_if.req_valid = v;
    bus_if.req_data  = d;
    #1;
    if (integ) chk("no_write_while_full", int'(bus_if.fifo_wr_en & bus_if.fifo_full), 0);
    if (bus_if.fifo_wr_en) begin
      wr_data.push_back(int'(bus_if.fifo_wr_data));
      wr_gnt.push_back(int'(grant_id));
      wr_cyc.push_back(cyc_n);
      if (integ) mq.push_back(bus_if.fifo_wr_data);
    end
    for (int i = 0; i < NR; i++)
      if (v[i] && bus_if.req_ready[i]) void'(src_q[i].pop_front());
    if (integ && (cyc_n % 3 == 2) && mq.size() > 0) rd.push_back(int'(mq.pop_front()));
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      drive_sample();
      advance();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bp    = 1'b0;
    integ = 1'b0;
    en    = 4'hF;
    bus_if.req_valid = '0;
    bus_if.req_data  = '0;
    bus_if.fifo_full = 1'b0;
    clear_all();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc_n = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_d [6];
    int exp_c [6];
    int b, r, w;

    // Reset with every requester asserting valid
    bus_if.req_valid = '1;
    bus_if.req_data  = 64'h1234_5678_9ABC_DEF0;
    bus_if.fifo_full = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_req_ready", int'(bus_if.req_ready), 0);
    chk("rst_wr_en", int'(bus_if.fifo_wr_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_grant_id", int'(grant_id), 0);
    chk("rst_wr_data", int'(bus_if.fifo_wr_data), 0);
    rst_n = 1'b1;
    cyc_n = 0;
    for (int i = 0; i < NR; i++) src_q[i].push_back(16'(16'h00A0 + i));
    drive_sample();
    chk("rst_first_idle_busy", int'(busy), 0);
    advance();
    drive_sample();
    chk("rst_first_grant", int'(grant_id), 0);
    chk("rst_first_busy", int'(busy), 1);
    chk("rst_first_wr_en", int'(bus_if.fifo_wr_en), 1);
    chk("rst_first_data", int'(bus_if.fifo_wr_data), 16'h00A0);
    chk("rst_first_ready", int'(bus_if.req_ready), 4'b0001);
    advance();

    // Single requester: burst of 4, one bubble, then the remaining 2
    do_reset();
    for (int k = 1; k <= 6; k++) src_q[1].push_back(16'(k));
    run(12);
    exp_d = '{1, 2, 3, 4, 5, 6};
    exp_c = '{1, 2, 3, 4, 6, 7};
    chk("single_count", wr_data.size(), 6);
    for (int j = 0; j < 6 && j < wr_data.size(); j++) begin
      chk("single_data", wr_data[j], exp_d[j]);
      chk("single_cycle", wr_cyc[j], exp_c[j]);
      chk("single_grant", wr_gnt[j], 1);
    end

    // Round-robin among four saturated requesters
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 8; k++) src_q[i].push_back(16'(i * 256 + k));
    run(45);
    chk("rr_count", wr_data.size(), 32);
    for (int j = 0; j < 32 && j < wr_data.size(); j++) begin
      b = j / 4;
      r = b % 4;
      w = (b / 4) * 4 + j % 4;
      chk("rr_data", wr_data[j], r * 256 + w);
      chk("rr_grant", wr_gnt[j], r);
      chk("rr_cycle", wr_cyc[j], 1 + j + j / 4);
    end

    // Back-pressure after beat 2 of requester 2, for cycles 3..7
    do_reset();
    for (int k = 1; k <= 4; k++) src_q[2].push_back(16'(16'h0200 + k));
    for (int c = 0; c < 12; c++) begin
      bp = (c >= 3 && c <= 7);
      drive_sample();
      if (c >= 3 && c <= 7) begin
        chk("bp_wr_en", int'(bus_if.fifo_wr_en), 0);
        chk("bp_ready", int'(bus_if.req_ready), 0);
        chk("bp_busy", int'(busy), 1);
        chk("bp_grant", int'(grant_id), 2);
        chk("bp_beat_cnt", int'(dut.beat_cnt), 2);
      end
      advance();
    end
    exp_c[0:3] = '{1, 2, 8, 9};
    chk("bp_count", wr_data.size(), 4);
    for (int j = 0; j < 4 && j < wr_data.size(); j++) begin
      chk("bp_data", wr_data[j], 16'h0201 + j);
      chk("bp_cycle", wr_cyc[j], exp_c[j]);
    end

    // Early release: requester 3 runs dry after 2 beats, then 0,1,2 in order
    do_reset();
    src_q[3].push_back(16'h0301);
    src_q[3].push_back(16'h0302);
    src_q[0].push_back(16'h0001);
    src_q[1].push_back(16'h0101);
    src_q[2].push_back(16'h0201);
    for (int c = 0; c < 15; c++) begin
      en = (c == 0) ? 4'b1000 : 4'b1111;
      drive_sample();
      if (c == 4) begin
        chk("early_idle_busy", int'(busy), 0);
        chk("early_last_grant", int'(dut.last_grant), 3);
      end
      advance();
    end
    exp_d[0:4] = '{16'h0301, 16'h0302, 16'h0001, 16'h0101, 16'h0201};
    exp_c[0:4] = '{1, 2, 5, 8, 11};
    chk("early_count", wr_data.size(), 5);
    for (int j = 0; j < 5 && j < wr_data.size(); j++) begin
      chk("early_data", wr_data[j], exp_d[j]);
      chk("early_cycle", wr_cyc[j], exp_c[j]);
    end

    // Asynchronous reset during beat 3 of requester 1
    do_reset();
    for (int k = 1; k <= 8; k++) src_q[1].push_back(16'(16'h0100 + k));
    for (int c = 0; c < 4; c++) begin
      drive_sample();
      if (c < 3) advance();
    end
    chk("async_pre_busy", int'(busy), 1);
    chk("async_pre_data", int'(bus_if.fifo_wr_data), 16'h0103);
    rst_n = 1'b0;
    #1;
    chk("async_wr_en", int'(bus_if.fifo_wr_en), 0);
    chk("async_ready", int'(bus_if.req_ready), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_grant", int'(grant_id), 0);
    chk("async_wr_data", int'(bus_if.fifo_wr_data), 0);
    do_reset();
    src_q[1].push_back(16'h0111);
    src_q[1].push_back(16'h0112);
    src_q[2].push_back(16'h0211);
    src_q[2].push_back(16'h0212);
    run(10);
    exp_d[0:3] = '{16'h0111, 16'h0112, 16'h0211, 16'h0212};
    exp_c[0:3] = '{1, 2, 5, 6};
    chk("post_rst_count", wr_data.size(), 4);
    for (int j = 0; j < 4 && j < wr_data.size(); j++) begin
      chk("post_rst_data", wr_data[j], exp_d[j]);
      chk("post_rst_cycle", wr_cyc[j], exp_c[j]);
      chk("post_rst_grant", wr_gnt[j], (j < 2) ? 1 : 2);
    end

    // Integration with a 16-deep FIFO drained once every 3 cycles
    do_reset();
    integ = 1'b1;
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 8; k++) src_q[i].push_back(16'(i * 256 + k));
    for (int c = 0; c < 400 && rd.size() < 32; c++) begin
      drive_sample();
      advance();
    end
    chk("integ_read_count", rd.size(), 32);
    for (int j = 0; j < 32 && j < rd.size(); j++) begin
      b = j / 4;
      r = b % 4;
      w = (b / 4) * 4 + j % 4;
      chk("integ_order", rd[j], r * 256 + w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
